// File: rtl/key_expansion.sv
// AES-256 key schedule: captures the cipher key on reset, then streams rk0..rk14 one per clock.
// Optional build macro KEYEXP_WRAP_EN: restart at rk0 after rk14 instead of holding rk14.

module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] subst
);
    // FIPS-197 forward S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign subst = SBOX[{~data, 3'b000} +: 8];
endmodule

module key_expansion #(
    parameter int NR = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] key,
    output logic [127:0] out_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         done
);
    // state   | meaning
    // ST_LOAD | key captured, next edge presents rk0
    // ST_RUN  | streaming rk0..rk14, one per edge
    // ST_HOLD | rk14 presented, holding until next reset
    typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_HOLD} state_t;

    localparam logic [3:0] LAST = 4'(NR);

    state_t       state, state_nxt;
    logic [255:0] key_q;
    logic [255:0] win, win_nxt;
    logic [127:0] out_key_nxt, rk_new;
    logic [3:0]   idx_nxt, k_new;
    logic         valid_nxt, done_nxt;
    logic [31:0]  last_w, sub_in, sub_out, t_word;
    logic [31:0]  w0, w1, w2, w3;
    logic [7:0]   rcon;

    // win holds {rk[k-2], rk[k-1]} relative to the key about to be produced
    assign last_w = win[31:0];
    assign k_new  = round_idx + 4'd1;
    assign sub_in = k_new[0] ? last_w : {last_w[23:0], last_w[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .data  (sub_in[8*g +: 8]),
            .subst (sub_out[8*g +: 8])
        );
    end

    // even keys open with rot+sub+rcon, odd keys with sub only
    assign rcon   = 8'h01 << (k_new[3:1] - 3'd1);
    assign t_word = k_new[0] ? sub_out : (sub_out ^ {rcon, 24'h000000});
    assign w0     = win[255:224] ^ t_word;
    assign w1     = win[223:192] ^ w0;
    assign w2     = win[191:160] ^ w1;
    assign w3     = win[159:128] ^ w2;
    assign rk_new = {w0, w1, w2, w3};

    always_comb begin
        state_nxt   = state;
        win_nxt     = win;
        out_key_nxt = out_key;
        idx_nxt     = round_idx;
        valid_nxt   = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            ST_LOAD: begin
                win_nxt     = key_q;
                out_key_nxt = key_q[255:128];
                idx_nxt     = 4'd0;
                valid_nxt   = 1'b1;
                state_nxt   = ST_RUN;
            end
            ST_RUN: begin
                valid_nxt = 1'b1;
                if (round_idx == LAST) begin
`ifdef KEYEXP_WRAP_EN
                    win_nxt     = key_q;
                    out_key_nxt = key_q[255:128];
                    idx_nxt     = 4'd0;
`else
                    valid_nxt   = 1'b0;
                    state_nxt   = ST_HOLD;
`endif
                end else begin
                    idx_nxt  = k_new;
                    done_nxt = (k_new == LAST);
                    if (round_idx == 4'd0) begin
                        out_key_nxt = win[127:0];
                    end else begin
                        out_key_nxt = rk_new;
                        win_nxt     = {win[127:0], rk_new};
                    end
                end
            end
            ST_HOLD: begin
                state_nxt = ST_HOLD;
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            key_q     <= key;
            win       <= '0;
            out_key   <= '0;
            round_idx <= '0;
            key_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            win       <= win_nxt;
            out_key   <= out_key_nxt;
            round_idx <= idx_nxt;
            key_valid <= valid_nxt;
            done      <= done_nxt;
        end
    end
endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: word-level FIPS-197 schedule model with an S-box derived from GF(2^8) inversion.
// Honours KEYEXP_WRAP_EN for the post-rk14 expectations.

module tb_key_expansion;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] key;
    logic [127:0] out_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_rk   [15];

    always #5 clk = ~clk;

    key_expansion dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .out_key   (out_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .done      (done)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int b = 0; b < 256; b++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] r;
            logic [7:0] s;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            r = inv;
            s = inv;
            for (int j = 0; j < 4; j++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox_tab[b] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0)
                t = sub_word({t[23:0], t[31:24]}) ^ ({24'h0, 8'h01 << (i/8 - 1)} << 24);
            else if (i % 8 == 4)
                t = sub_word(t);
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_edge(input string tag, input int k);
        chk({tag, "_key"},   out_key,          exp_rk[k]);
        chk({tag, "_idx"},   128'(round_idx),  128'(k));
        chk({tag, "_valid"}, 128'(key_valid),  128'(1));
        chk({tag, "_done"},  128'(done),       128'(k == 14));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_key"},   out_key,         128'h0);
        chk({tag, "_idx"},   128'(round_idx), 128'h0);
        chk({tag, "_valid"}, 128'(key_valid), 128'h0);
        chk({tag, "_done"},  128'(done),      128'h0);
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    task automatic load_key(input logic [255:0] k);
        key = k;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expand(k);
    endtask

    task automatic run_stream(input string tag);
        for (int k = 0; k < 15; k++) begin
            tick();
            check_edge(tag, k);
        end
    endtask

    initial begin
        logic [255:0] k1, ka, kb;
        rst = 1'b1;
        k1  = 256'h642423baa95efb4362d3f2ce993c0904150f258aa1fe796841d7b4429c9b5a30;
        key = k1;
        build_sbox();

        tick();
        tick();
        check_reset("reset");

        // key changes after release must not disturb the stream
        expand(k1);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (k == 3) key = rand_key();
            check_edge("k1", k);
            if (k == 0) chk("spec_e1", out_key, 128'h642423baa95efb4362d3f2ce993c0904);
            if (k == 1) chk("spec_e2", out_key, 128'h150f258aa1fe796841d7b4429c9b5a30);
            if (k == 2) chk("spec_e3", out_key, 128'h719a2764d8c4dc27ba172ee9232b27ed);
        end
        for (int m = 16; m <= 20; m++) begin
            tick();
`ifdef KEYEXP_WRAP_EN
            check_edge("wrap", (m - 1) % 15);
`else
            chk("hold_key",   out_key,         exp_rk[14]);
            chk("hold_idx",   128'(round_idx), 128'd14);
            chk("hold_valid", 128'(key_valid), 128'h0);
            chk("hold_done",  128'(done),      128'h0);
`endif
        end

        load_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        for (int k = 0; k < 15; k++) begin
            tick();
            check_edge("fips", k);
            if (k == 2)  chk("fips_rk2",  out_key, 128'ha573c29fa176c498a97fce93a572c09c);
            if (k == 14) chk("fips_rk14", out_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        end

        load_key(256'h0);
        for (int k = 0; k < 15; k++) begin
            tick();
            check_edge("zero", k);
            if (k == 2) chk("zero_rk2", out_key, 128'h62636363626363636263636362636363);
        end

        for (int n = 0; n < 3; n++) begin
            load_key(rand_key());
            run_stream("rand");
        end

        // reset in mid-expansion takes priority and reloads the new key
        ka = rand_key();
        kb = rand_key();
        load_key(ka);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_edge("mid_a", k);
        end
        key = kb;
        rst = 1'b1;
        tick();
        check_reset("mid_rst");
        rst = 1'b0;
        expand(kb);
        run_stream("mid_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
